serializer_pipe: RTL and testbench
==================================

// Module: serializer_pipe
// PURPOSE
//  Parametrised parallel-to-serial converter. Successor of the fixed 16-bit serializer.
//  Adds configurable word width, MSB- or LSB-first order and a valid/ready input handshake.
//  A 1-deep holding register gives back-to-back output with no idle cycle between words.
//  Sits between word-producing logic and a single-bit serial link, one bit per clk_i.
// PARAMETERS
//  DATA_W     16                 word width in bits, >= 4
//  MOD_W      $clog2(DATA_W)     width of data_mod_i
//  MIN_LEN    3                  shortest legal word length; shorter words are dropped
//  LSB_FIRST  0                  0: MSB-first from data_i[DATA_W-1]; 1: LSB-first from data_i[0]
// PORTS
//  clk_i            in   1        clock; single clock domain
//  srst_i           in   1        synchronous reset, active-high
//  data_i           in   DATA_W   parallel word
//  data_mod_i       in   MOD_W    bit count L; 0 means L = DATA_W
//  data_val_i       in   1        word valid
//  ready_o          out  1        holding register empty; a word is accepted when data_val_i && ready_o
//  ser_data_o       out  1        serial bit; 0 whenever ser_data_val_o = 0
//  ser_data_val_o   out  1        serial bit valid
//  ser_last_o       out  1        high with the final bit of each word
//  busy_o           out  1        shifter active OR holding register full
//  drop_o           out  1        1-cycle pulse: accepted word had 1 <= L < MIN_LEN and was discarded
// BEHAVIOUR
//  - Reset values: ready_o = 1; all other outputs = 0. Shifter, holding register and counter are cleared.
//  - Reset mid-word: every in-flight and held word is lost. Outputs return to reset values on the next cycle.
//  - All outputs are registered.
//  - Length: L = (data_mod_i == 0) ? DATA_W : data_mod_i, captured at accept.
//    MSB-first emits data_i[DATA_W-1] down to data_i[DATA_W-L].
//    LSB-first emits data_i[0] up to data_i[L-1].
//  - Latency: word accepted at edge N with the shifter idle or on its last bit -> first bit valid at N+1.
//  - Load priority into the shifter, evaluated when the shifter is idle or emitting its last bit:
//    1. holding register, if full;
//    2. otherwise the accepted input, which bypasses the holding register.
//    Otherwise an accepted word goes to the holding register and ready_o drops on the next cycle.
//  - Back-to-back: word B's first bit is in the cycle directly after word A's ser_last_o.
//  - Simultaneous events: holding register moves to the shifter on the same edge a new word arrives.
//    ready_o was 0, so no accept is possible; ready_o rises on the next cycle.
//  - Counter: MOD_W+1 bits, down-counts L-1 to 0. ser_last_o is asserted when count = 0.
//  - Dropped word (1 <= L < MIN_LEN):
//    no serial bits are emitted and shifter state is untouched;
//    drop_o pulses at N+1;
//    the word never occupies the holding register, so ready_o stays 1.
//  - data_val_i while ready_o = 0: ignored. The producer must hold the word.
//  - FSM (shifter): IDLE -> SHIFT on load. SHIFT -> SHIFT on last bit if a load is pending, else SHIFT -> IDLE.
// STRUCTURE
//  - serializer_pkg:
//    typedef struct {data, len} ser_word_t;
//    enum {SER_IDLE, SER_SHIFT} ser_state_t;
//    function ser_len(mod, DATA_W).
//  - Sub-module ser_shift_core: shift register, counter and FSM; load/len in, bit/val/last out.
//  - Top level: handshake, holding register, drop detection, bypass mux.
// TESTING
//  1. DATA_W=16, MSB-first, word 0xA5F0, mod=0 -> 16 bits 1010_0101_1111_0000 at N+1..N+16.
//     ser_last_o at N+16; busy_o low at N+17.
//  2. mod=4, data 0xC000 -> bits 1,1,0,0, last on the 4th bit.
//     Same with LSB_FIRST=1 and data 0x0003 -> bits 1,1,0,0.
//  3. Three words with data_val_i held high -> ready_o low while one word is held; 16+8+5 contiguous valid cycles.
//     Exactly 3 ser_last_o pulses; no gap cycles.
//  4. mod=2 while idle -> drop_o pulse at N+1; no ser_data_val_o; ready_o stays 1.
//     mod=3 -> 3 bits emitted.
//  5. srst_i asserted on the 7th bit of a word with a second word held -> next cycle all outputs 0 and ready_o = 1.
//     A new word after reset emits cleanly.
//  6. Randomised words/lengths against a reference queue model: serial stream and last markers match.
//     ser_data_o = 0 whenever ser_data_val_o = 0.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// Word storage is sized for the widest supported configuration (64 bits).
package serializer_pkg;

  localparam int SER_MAX_W = 64;
  localparam int SER_LEN_W = 7;

  typedef struct packed {
    logic [SER_MAX_W-1:0] data;
    logic [SER_LEN_W-1:0] len;
  } ser_word_t;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // A length field of zero stands for a full-width word.
  function automatic logic [SER_LEN_W-1:0] ser_len(input logic [SER_LEN_W-1:0] mod,
                                                   input int data_w);
    return (mod == '0) ? SER_LEN_W'(data_w) : mod;
  endfunction

endpackage

// File: rtl/ser_shift_core.sv
// Shift register, bit counter and shifter FSM; emits one bit per clock after a load.
//   state     | meaning
//   SER_IDLE  | no word in flight, serial outputs low
//   SER_SHIFT | emitting a word; cnt_q = bits remaining after the current one
module ser_shift_core
  import serializer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 5,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [CNT_W-1:0]  load_len_i,
  output logic              can_load_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o
);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;

  assign can_load_o = (state_q == SER_IDLE) || (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= SER_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (load_i) state_d = SER_SHIFT;
      SER_SHIFT: if (cnt_q == '0) state_d = load_i ? SER_SHIFT : SER_IDLE;
      default:   state_d = SER_IDLE;
    endcase
  end

  // Register is cleared when going idle so the serial bit reads 0 between words.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i && can_load_o) begin
      shreg_q <= load_data_i;
      cnt_q   <= load_len_i - CNT_W'(1);
      last_q  <= (load_len_i == CNT_W'(1));
    end else if (state_q == SER_SHIFT) begin
      if (cnt_q == '0) begin
        shreg_q <= '0;
        last_q  <= 1'b0;
      end else begin
        shreg_q <= LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_q   <= cnt_q - CNT_W'(1);
        last_q  <= (cnt_q == CNT_W'(1));
      end
    end
  end

  assign ser_data_o     = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];
  assign ser_data_val_o = (state_q == SER_SHIFT);
  assign ser_last_o     = last_q;

endmodule

// File: rtl/serializer_pipe.sv
// Parallel-to-serial converter with valid/ready input, 1-deep holding register
// and short-word drop; the holding register keeps words back-to-back on the link.
module serializer_pipe
  import serializer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int MIN_LEN   = 3,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int CNT_W = MOD_W + 1;
  localparam logic [SER_MAX_W-1:0] DATA_MASK = SER_MAX_W'({DATA_W{1'b1}});

  ser_word_t         in_word, hold_q;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  in_len, load_len;
  logic [DATA_W-1:0] load_data;
  logic              accept, in_drop, in_ok;
  logic              core_can_load, core_load;
  logic              unused_hold;

  always_comb begin
    in_word      = '0;
    in_word.data = SER_MAX_W'(data_i);
    in_word.len  = ser_len(SER_LEN_W'(data_mod_i), DATA_W);
  end

  assign in_len  = CNT_W'(in_word.len);
  assign accept  = data_val_i & ready_o;
  assign in_drop = accept & (in_len < CNT_W'(MIN_LEN));
  assign in_ok   = accept & ~in_drop;

  // A held word always wins the shifter; a fresh word only bypasses when nothing is held.
  always_comb begin
    core_load   = 1'b0;
    load_data   = data_i;
    load_len    = in_len;
    hold_full_d = hold_full_q;
    if (core_can_load && hold_full_q) begin
      core_load   = 1'b1;
      load_data   = hold_q.data[DATA_W-1:0];
      load_len    = CNT_W'(hold_q.len);
      hold_full_d = 1'b0;
    end else if (core_can_load && in_ok) begin
      core_load = 1'b1;
    end else if (in_ok) begin
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_o     <= 1'b1;
      drop_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (in_ok && !core_can_load) hold_q <= in_word;
      ready_o     <= ~hold_full_d;
      drop_o      <= in_drop;
      busy_o      <= core_load | (ser_data_val_o & ~ser_last_o) | hold_full_d;
    end
  end

  assign unused_hold = ^{hold_q.data & ~DATA_MASK, hold_q.len};

  ser_shift_core #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_core (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .load_i        (core_load),
    .load_data_i   (load_data),
    .load_len_i    (load_len),
    .can_load_o    (core_can_load),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .ser_last_o    (ser_last_o)
  );

endmodule

// File: tb/tb_serializer_pipe.sv
// Bench for serializer_pipe: MSB-first and LSB-first instances share one stimulus;
// directed vectors plus a randomized run against a queue-based stream model.
module tb_serializer_pipe;

  localparam int DW = 16;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;

  logic rdy_m, bit_m, val_m, last_m, busy_m, drop_m;
  logic rdy_l, bit_l, val_l, last_l, busy_l, drop_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  serializer_pipe #(.DATA_W(DW), .LSB_FIRST(1'b0)) dut_m (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ready_o(rdy_m), .ser_data_o(bit_m),
    .ser_data_val_o(val_m), .ser_last_o(last_m), .busy_o(busy_m), .drop_o(drop_m));

  serializer_pipe #(.DATA_W(DW), .LSB_FIRST(1'b1)) dut_l (
    .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ready_o(rdy_l), .ser_data_o(bit_l),
    .ser_data_val_o(val_l), .ser_last_o(last_l), .busy_o(busy_l), .drop_o(drop_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word of legal length becomes its list of
  // {bit, last} pairs in emission order; short words become one drop pulse.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic       exp_drop = 1'b0;
  int         mdl_len;

  always @(posedge clk_i) begin
    if (srst_i) begin
      q_m.delete();
      q_l.delete();
      exp_drop <= 1'b0;
    end else begin
      exp_drop <= 1'b0;
      if (data_val_i && rdy_m) begin
        mdl_len = (data_mod_i == 4'd0) ? DW : int'(data_mod_i);
        if (mdl_len < 3) exp_drop <= 1'b1;
        else
          for (int k = 0; k < mdl_len; k++) begin
            q_m.push_back({data_i[DW-1-k], k == mdl_len-1});
            q_l.push_back({data_i[k], k == mdl_len-1});
          end
      end
    end
  end

  logic [1:0] e_m, e_l;
  always @(negedge clk_i) begin
    if (val_m) begin
      check("m_bit_expected", q_m.size() != 0, 1);
      if (q_m.size() != 0) begin
        e_m = q_m.pop_front();
        check("m_stream_bit", bit_m, e_m[1]);
        check("m_stream_last", last_m, e_m[0]);
      end
    end else begin
      check("m_idle_data", bit_m, 0);
      check("m_idle_last", last_m, 0);
    end
    if (val_l) begin
      check("l_bit_expected", q_l.size() != 0, 1);
      if (q_l.size() != 0) begin
        e_l = q_l.pop_front();
        check("l_stream_bit", bit_l, e_l[1]);
        check("l_stream_last", last_l, e_l[0]);
      end
    end else begin
      check("l_idle_data", bit_l, 0);
      check("l_idle_last", last_l, 0);
    end
    check("m_drop", drop_m, exp_drop);
    check("l_drop", drop_l, exp_drop);
  end

  // Present a word from a negedge and hold it until accepted; returns at the
  // negedge right after the accepting edge with data_val_i cleared.
  task automatic send(input logic [15:0] d, input logic [3:0] m);
    int guard;
    guard = 0;
    data_i = d; data_mod_i = m; data_val_i = 1'b1;
    while (!rdy_m && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check("send_ready_timeout", guard < 100, 1);
    @(negedge clk_i);
    data_val_i = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          len;
    logic        drop;
    logic [15:0] seq_m;  // emitted bits, first bit in [15]
    logic [15:0] seq_l;
  } vec_t;

  vec_t vecs[7];
  int   t3_g, t3_run, t3_lasts, dr_g;
  bit   t3_low;
  logic [3:0] nib;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hA5F0, 4'd0, 16, 1'b0, 16'hA5F0, 16'h0FA5};
    vecs[1] = '{16'hC000, 4'd4, 4,  1'b0, 16'hC000, 16'h0000};
    vecs[2] = '{16'h0003, 4'd4, 4,  1'b0, 16'h0000, 16'hC000};
    vecs[3] = '{16'hFFFF, 4'd2, 0,  1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{16'hE001, 4'd3, 3,  1'b0, 16'hE000, 16'h8000};
    vecs[5] = '{16'h1234, 4'd5, 5,  1'b0, 16'h1000, 16'h2800};
    vecs[6] = '{16'h8001, 4'd1, 0,  1'b1, 16'h0000, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ready", rdy_m, 1);
    check("rst_val", val_m, 0);
    check("rst_data", bit_m, 0);
    check("rst_last", last_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_drop", drop_m, 0);
    check("rst_ready_l", rdy_l, 1);
    srst_i = 1'b0;

    // Single words from idle: latency, bit order, last marker, drop
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      check("vec_ready_before", rdy_m, 1);
      data_i = vecs[i].data; data_mod_i = vecs[i].mod; data_val_i = 1'b1;
      @(negedge clk_i);
      data_val_i = 1'b0;
      if (vecs[i].drop) begin
        check("vec_drop_pulse", drop_m, 1);
        check("vec_drop_pulse_l", drop_l, 1);
        check("vec_drop_noval", val_m, 0);
        check("vec_drop_ready", rdy_m, 1);
        check("vec_drop_busy", busy_m, 0);
      end else begin
        for (int k = 0; k < vecs[i].len; k++) begin
          if (k > 0) @(negedge clk_i);
          check("vec_val", val_m, 1);
          check("vec_bit_m", bit_m, vecs[i].seq_m[15-k]);
          check("vec_bit_l", bit_l, vecs[i].seq_l[15-k]);
          check("vec_last_m", last_m, k == vecs[i].len-1);
          check("vec_last_l", last_l, k == vecs[i].len-1);
          check("vec_busy", busy_m, 1);
        end
      end
      @(negedge clk_i);
      check("vec_after_val", val_m, 0);
      check("vec_after_busy", busy_m, 0);
      check("vec_after_drop", drop_m, 0);
    end

    // Three words with valid held high: 16+8+5 contiguous bits, one held word
    @(negedge clk_i);
    t3_g = 0; t3_run = 0; t3_lasts = 0; t3_low = 1'b0;
    fork
      begin
        send(16'hA5F0, 4'd0);
        send(16'h1234, 4'd8);
        send(16'hBEEF, 4'd5);
      end
      begin
        while (!val_m && t3_g < 50) begin
          @(negedge clk_i);
          t3_g++;
        end
        while (val_m && t3_run < 100) begin
          t3_run++;
          if (last_m) t3_lasts++;
          if (!rdy_m) t3_low = 1'b1;
          @(negedge clk_i);
        end
      end
    join
    check("b2b_run_len", t3_run, 29);
    check("b2b_last_count", t3_lasts, 3);
    check("b2b_ready_dropped", t3_low, 1);
    check("b2b_busy_after", busy_m, 0);

    // Reset on the 7th bit of a word with a second word held
    @(negedge clk_i);
    data_i = 16'hFFFF; data_mod_i = 4'd0; data_val_i = 1'b1;
    @(negedge clk_i);
    data_i = 16'h1234; data_mod_i = 4'd0;
    @(negedge clk_i);
    data_val_i = 1'b0;
    check("rstmid_held_ready", rdy_m, 0);
    repeat (5) @(negedge clk_i);
    check("rstmid_val_before", val_m, 1);
    check("rstmid_bit_before", bit_m, 1);
    srst_i = 1'b1;
    @(negedge clk_i);
    srst_i = 1'b0;
    check("rstmid_val", val_m, 0);
    check("rstmid_data", bit_m, 0);
    check("rstmid_last", last_m, 0);
    check("rstmid_busy", busy_m, 0);
    check("rstmid_drop", drop_m, 0);
    check("rstmid_ready", rdy_m, 1);
    check("rstmid_ready_l", rdy_l, 1);
    check("rstmid_busy_l", busy_l, 0);
    @(negedge clk_i);
    data_i = 16'hC000; data_mod_i = 4'd4; data_val_i = 1'b1;
    @(negedge clk_i);
    data_val_i = 1'b0;
    nib = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_i);
      check("post_rst_val", val_m, 1);
      check("post_rst_bit", bit_m, nib[3-k]);
      check("post_rst_last", last_m, k == 3);
    end
    @(negedge clk_i);
    check("post_rst_idle", val_m, 0);

    // Randomized words, lengths and gaps against the stream model
    for (int w = 0; w < 150; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send(16'($urandom), 4'($urandom_range(0, 15)));
    end
    dr_g = 0;
    while ((q_m.size() != 0 || val_m) && dr_g < 300) begin
      @(negedge clk_i);
      dr_g++;
    end
    check("drain_timeout", dr_g < 300, 1);
    check("drain_q_m", q_m.size(), 0);
    check("drain_q_l", q_l.size(), 0);
    @(negedge clk_i);
    check("final_busy", busy_m, 0);
    check("final_ready", rdy_m, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
